// File: rtl/mac_wave_col_scheduler.sv
// Column sequencer for a bit-serial wave MAC: latches one sign-magnitude weight vector per job
// and streams its magnitude columns MSB first, then a drain cycle and a one-cycle done pulse.
module mac_wave_col_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 8,
    parameter int COL_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] w_in [VEC_LENGTH],
    input  logic                  skip_zero_cols,
    input  logic                  stall,
    output logic                  mac_en,
    output logic                  mac_load_accum,
    output logic [VEC_LENGTH-1:0] mac_sign,
    output logic [VEC_LENGTH-1:0] mac_w_bit,
    output logic [COL_BITS-1:0]   mac_column_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int MAG_W = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [MAG_W-1:0]      r_mask;
    logic [MAG_W-1:0]      r_mag [VEC_LENGTH];
    logic                  r_first;
    logic                  r_en;
    logic                  r_load;
    logic                  r_done;
    logic [VEC_LENGTH-1:0] r_sign;
    logic [VEC_LENGTH-1:0] r_w_bit;
    logic [COL_BITS-1:0]   r_col;

    logic [VEC_LENGTH-1:0] w_in_cols  [MAG_W];
    logic [VEC_LENGTH-1:0] w_lat_cols [MAG_W];
    logic [MAG_W-1:0]      w_in_col_any;
    logic [VEC_LENGTH-1:0] w_in_sign;
    logic [MAG_W-1:0]      w_acc_mask;
    logic [COL_BITS-1:0]   w_acc_col;
    logic [MAG_W-1:0]      w_acc_rest;
    logic [COL_BITS-1:0]   w_nxt_col;
    logic [MAG_W-1:0]      w_nxt_rest;

    function automatic logic [COL_BITS-1:0] f_msb(input logic [MAG_W-1:0] m);
        logic [COL_BITS-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (m[i]) begin
                idx = COL_BITS'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [MAG_W-1:0] f_clear(input logic [MAG_W-1:0] m,
                                                 input logic [COL_BITS-1:0] c);
        logic [MAG_W-1:0] res;
        res    = m;
        res[c] = 1'b0;
        return res;
    endfunction

    // Transpose lanes into columns so a whole column can be selected by index.
    genvar gi, gj;
    generate
        for (gi = 0; gi < MAG_W; gi++) begin : g_col
            for (gj = 0; gj < VEC_LENGTH; gj++) begin : g_lane
                assign w_in_cols[gi][gj]  = w_in[gj][gi];
                assign w_lat_cols[gi][gj] = r_mag[gj][gi];
            end
            assign w_in_col_any[gi] = |w_in_cols[gi];
        end
        for (gi = 0; gi < VEC_LENGTH; gi++) begin : g_sign
            assign w_in_sign[gi] = w_in[gi][DATA_WIDTH-1];
        end
    endgenerate

    always_comb begin
        w_acc_mask = skip_zero_cols ? w_in_col_any : {MAG_W{1'b1}};
        // An all-zero job still issues column 0 so the MAC sees a normal en/load sequence.
        if (w_acc_mask == '0) begin
            w_acc_mask = {{(MAG_W-1){1'b0}}, 1'b1};
        end
    end

    assign w_acc_col  = f_msb(w_acc_mask);
    assign w_acc_rest = f_clear(w_acc_mask, w_acc_col);
    assign w_nxt_col  = f_msb(r_mask);
    assign w_nxt_rest = f_clear(r_mask, w_nxt_col);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_first <= 1'b0;
            r_en    <= 1'b0;
            r_load  <= 1'b0;
            r_done  <= 1'b0;
            r_sign  <= '0;
            r_w_bit <= '0;
            r_col   <= '0;
            for (int l = 0; l < VEC_LENGTH; l++) begin
                r_mag[l] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        for (int l = 0; l < VEC_LENGTH; l++) begin
                            r_mag[l] <= w_in[l][MAG_W-1:0];
                        end
                        r_sign  <= w_in_sign;
                        r_col   <= w_acc_col;
                        r_w_bit <= w_in_cols[w_acc_col];
                        r_mask  <= w_acc_rest;
                        r_en    <= 1'b1;
                        r_load  <= 1'b0;
                        r_first <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        // The en-cycle after the first consumed column carries load_accum.
                        r_first <= 1'b0;
                        r_load  <= r_first;
                        if (r_mask != '0) begin
                            r_col   <= w_nxt_col;
                            r_w_bit <= w_lat_cols[w_nxt_col];
                            r_mask  <= w_nxt_rest;
                        end else begin
                            r_w_bit <= '0;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        r_en    <= 1'b0;
                        r_load  <= 1'b0;
                        r_done  <= 1'b1;
                        r_col   <= '0;
                        r_sign  <= '0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall only gates the strobes; the presented column stays put until consumed.
    assign mac_en         = r_en & ~stall;
    assign mac_load_accum = r_load & ~stall;
    assign mac_sign       = r_sign;
    assign mac_w_bit      = r_w_bit;
    assign mac_column_idx = r_col;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign w_ready        = reset_n & (r_state == S_IDLE);

endmodule

// File: tb/tb_mac_wave_col_scheduler.sv
// Bench for mac_wave_col_scheduler: a queue-based model of each job's en-cycles, checked every cycle,
// plus literal expectations for the directed cases.
module tb_mac_wave_col_scheduler;

    localparam int DW = 8;
    localparam int VL = 8;
    localparam int CB = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          w_valid = 1'b0;
    logic          skip_zero_cols = 1'b0;
    logic          stall = 1'b0;
    logic [DW-1:0] w_in [VL];
    logic          w_ready;
    logic          mac_en;
    logic          mac_load_accum;
    logic [VL-1:0] mac_sign;
    logic [VL-1:0] mac_w_bit;
    logic [CB-1:0] mac_column_idx;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mac_wave_col_scheduler #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .COL_BITS(CB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_in           (w_in),
        .skip_zero_cols (skip_zero_cols),
        .stall          (stall),
        .mac_en         (mac_en),
        .mac_load_accum (mac_load_accum),
        .mac_sign       (mac_sign),
        .mac_w_bit      (mac_w_bit),
        .mac_column_idx (mac_column_idx),
        .busy           (busy),
        .done           (done)
    );

    // One entry per expected en-cycle of the current job (issued columns, then the drain).
    typedef struct {
        logic [2:0] col;
        logic [7:0] wbit;
        logic [7:0] sign;
        logic       load;
        logic       drain;
    } ent_t;

    ent_t        exp_q[$];
    int          m_phase = 0;   // 0 idle, 1 en-cycles pending, 2 done cycle
    int          m_ncols = 0;
    int          m_stalls = 0;
    int          acc_cyc = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          jobs = 0;
    int          obs_en = 0;
    int          obs_lat = 0;
    int          obs_load_idx = 0;
    logic [31:0] obs_seq = '0;
    logic [7:0]  obs_wbit_or = '0;
    logic        obs_done = 1'b0;
    logic [7:0]  wv [VL];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},    32'(mac_en), 0);
        chk({tag, "_load"},  32'(mac_load_accum), 0);
        chk({tag, "_wbit"},  32'(mac_w_bit), 0);
        chk({tag, "_sign"},  32'(mac_sign), 0);
        chk({tag, "_col"},   32'(mac_column_idx), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_ready"}, 32'(w_ready), 0);
    endtask

    task automatic check();
        ent_t h;
        if (!reset_n) begin
            chk_reset_outputs("rst");
            return;
        end
        case (m_phase)
            0: begin
                chk("idle_ready", 32'(w_ready), 1);
                chk("idle_busy",  32'(busy), 0);
                chk("idle_en",    32'(mac_en), 0);
                chk("idle_load",  32'(mac_load_accum), 0);
                chk("idle_done",  32'(done), 0);
                chk("idle_wbit",  32'(mac_w_bit), 0);
            end
            1: begin
                h = exp_q[0];
                chk("job_busy",  32'(busy), 1);
                chk("job_ready", 32'(w_ready), 0);
                chk("job_done",  32'(done), 0);
                chk("en",        32'(mac_en), stall ? 0 : 1);
                chk("load",      32'(mac_load_accum), stall ? 0 : 32'(h.load));
                chk("wbit",      32'(mac_w_bit), 32'(h.wbit));
                if (!h.drain) begin
                    chk("col",  32'(mac_column_idx), 32'(h.col));
                    chk("sign", 32'(mac_sign), 32'(h.sign));
                end
                if (mac_en) begin
                    obs_en++;
                    obs_seq = (obs_seq << 4) | 32'(mac_column_idx);
                    obs_wbit_or = obs_wbit_or | mac_w_bit;
                    if (mac_load_accum) obs_load_idx = obs_en;
                end
            end
            default: begin
                chk("done_pulse", 32'(done), 1);
                chk("done_en",    32'(mac_en), 0);
                chk("done_load",  32'(mac_load_accum), 0);
                chk("done_wbit",  32'(mac_w_bit), 0);
                chk("done_busy",  32'(busy), 1);
                chk("done_ready", 32'(w_ready), 0);
                obs_done = 1'b1;
                obs_lat  = cyc - acc_cyc;
                chk("latency", 32'(obs_lat), 32'(m_ncols + 2 + m_stalls));
                jobs++;
                $display("job %0d: cols=%0d stalls=%0d latency=%0d seq=%0h",
                         jobs, m_ncols, m_stalls, obs_lat, obs_seq >> 4);
            end
        endcase
    endtask

    task automatic build_job();
        ent_t e;
        logic any;
        exp_q.delete();
        m_ncols = 0;
        m_stalls = 0;
        acc_cyc = cyc;
        obs_en = 0;
        obs_seq = '0;
        obs_wbit_or = '0;
        obs_load_idx = 0;
        obs_done = 1'b0;
        for (int c = 6; c >= 0; c--) begin
            any = 1'b0;
            for (int l = 0; l < VL; l++) any = any | w_in[l][c];
            if (!skip_zero_cols || any) begin
                e.col = 3'(c);
                for (int l = 0; l < VL; l++) begin
                    e.wbit[l] = w_in[l][c];
                    e.sign[l] = w_in[l][7];
                end
                e.load  = (m_ncols == 1);
                e.drain = 1'b0;
                exp_q.push_back(e);
                m_ncols++;
            end
        end
        if (m_ncols == 0) begin
            e.col  = 3'd0;
            e.wbit = '0;
            for (int l = 0; l < VL; l++) e.sign[l] = w_in[l][7];
            e.load  = 1'b0;
            e.drain = 1'b0;
            exp_q.push_back(e);
            m_ncols = 1;
        end
        e.col   = 3'd0;
        e.wbit  = '0;
        e.sign  = '0;
        e.load  = (m_ncols == 1);
        e.drain = 1'b1;
        exp_q.push_back(e);
        m_phase = 1;
    endtask

    task automatic advance();
        if (reset_n) begin
            case (m_phase)
                0: if (w_valid) build_job();
                1: begin
                    if (stall) begin
                        m_stalls++;
                    end else begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && m_phase != 0; k++) step();
        if (m_phase != 0) begin
            chk("idle_timeout", 0, 1);
            m_phase = 0;
            exp_q.delete();
        end
    endtask

    task automatic do_job(input logic skip, input int st_at, input int st_len);
        wait_idle();
        for (int l = 0; l < VL; l++) w_in[l] = wv[l];
        skip_zero_cols = skip;
        stall = 1'b0;
        w_valid = 1'b1;
        obs_done = 1'b0;
        step();
        w_valid = 1'b0;
        for (int k = 1; k <= 40 && !obs_done; k++) begin
            stall = (k >= st_at && k < st_at + st_len);
            step();
        end
        stall = 1'b0;
        if (!obs_done) chk("done_timeout", 0, 1);
    endtask

    logic [31:0] cm;

    initial begin
        for (int l = 0; l < VL; l++) w_in[l] = '0;
        step();
        step();
        reset_n = 1'b1;
        step();

        // Case 1: every lane 0x01.
        for (int l = 0; l < VL; l++) wv[l] = 8'h01;
        do_job(1'b1, 0, 0);
        chk("c1_latency", 32'(obs_lat), 3);
        chk("c1_en_cycles", 32'(obs_en), 2);
        chk("c1_load_idx", 32'(obs_load_idx), 2);
        chk("c1_wbit", 32'(obs_wbit_or), 32'hFF);

        // Case 2: lane0 0x85 -> columns 2 then 0.
        for (int l = 0; l < VL; l++) wv[l] = 8'h00;
        wv[0] = 8'h85;
        do_job(1'b1, 0, 0);
        chk("c2_latency", 32'(obs_lat), 4);
        chk("c2_seq", obs_seq >> 4, 32'h20);
        chk("c2_load_idx", 32'(obs_load_idx), 2);

        // Case 3: only signs set -> single all-zero column 0.
        for (int l = 0; l < VL; l++) wv[l] = l[0] ? 8'h80 : 8'h00;
        do_job(1'b1, 0, 0);
        chk("c3_latency", 32'(obs_lat), 3);
        chk("c3_en_cycles", 32'(obs_en), 2);
        chk("c3_wbit", 32'(obs_wbit_or), 0);

        // Case 4: lane3 0x7F, no skipping.
        for (int l = 0; l < VL; l++) wv[l] = 8'h00;
        wv[3] = 8'h7F;
        do_job(1'b0, 0, 0);
        chk("c4_latency", 32'(obs_lat), 9);
        chk("c4_seq", obs_seq >> 4, 32'h6543210);
        chk("c4_wbit", 32'(obs_wbit_or), 32'h08);

        // Case 5: case 2 with a two-cycle stall on the second issue.
        for (int l = 0; l < VL; l++) wv[l] = 8'h00;
        wv[0] = 8'h85;
        do_job(1'b1, 2, 2);
        chk("c5_latency", 32'(obs_lat), 6);
        chk("c5_load_idx", 32'(obs_load_idx), 2);
        chk("c5_en_cycles", 32'(obs_en), 3);

        // Case 6: asynchronous reset in the middle of issue.
        wait_idle();
        for (int l = 0; l < VL; l++) w_in[l] = 8'h00;
        w_in[3] = 8'h7F;
        skip_zero_cols = 1'b0;
        w_valid = 1'b1;
        step();
        w_valid = 1'b0;
        step();
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("c6_async");
        exp_q.delete();
        m_phase = 0;
        obs_done = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("c6_no_done", 32'(obs_done), 0);
        for (int l = 0; l < VL; l++) wv[l] = 8'h01;
        do_job(1'b1, 0, 0);
        chk("c6_after_latency", 32'(obs_lat), 3);

        // Randomized traffic with stalls, gaps and sparse weights.
        for (int n = 0; n < 1500; n++) begin
            w_valid = ($urandom % 3) != 0;
            skip_zero_cols = 1'($urandom);
            stall = ($urandom % 4) == 0;
            cm = $urandom;
            if ($urandom % 8 == 0) cm = '0;
            for (int l = 0; l < VL; l++) w_in[l] = {1'($urandom), 7'($urandom) & cm[6:0]};
            step();
        end
        w_valid = 1'b0;
        stall = 1'b0;
        wait_idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
